// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller and its clients.
package irq_pkg;

    typedef enum logic [1:0] {
        ICIdle,
        ICArbitrate,
        ICAssert
    } IRQState;

    // Register addresses
    localparam logic [2:0] IRQ_PENDING = 3'd0;
    localparam logic [2:0] IRQ_MASK    = 3'd1;
    localparam logic [2:0] IRQ_ACTIVE  = 3'd2;
    localparam logic [2:0] IRQ_CTRL    = 3'd3;

    // CTRL register bit positions
    localparam int unsigned CTL_GIE = 0;
    localparam int unsigned CTL_EOI = 1;

    // Component ids, one per irq_in bit
    localparam int unsigned UART = 0;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of a request vector.
module irq_priority_encoder #(
    parameter int unsigned SOURCES  = 8,
    parameter int unsigned ID_WIDTH = 3
) (
    input  logic [SOURCES-1:0]  req,
    output logic                valid,
    output logic [ID_WIDTH-1:0] id
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches request pulses, masks them and
// presents the lowest enabled id to the CPU until an end-of-interrupt write.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned SOURCES    = 8,
    parameter int unsigned ID_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [SOURCES-1:0]    irq_in,
    output logic                  cpu_irq,
    output logic [ID_WIDTH-1:0]   cpu_irq_id
);

    IRQState             state_q, state_d;
    logic [SOURCES-1:0]  pending_q, pending_d;
    logic [SOURCES-1:0]  mask_q, mask_d;
    logic                gie_q, gie_d;
    logic [ID_WIDTH-1:0] active_id_q, active_id_d;

    logic                we;
    logic                eoi;
    logic [SOURCES-1:0]  w1c;
    logic [SOURCES-1:0]  eoi_clr;
    logic [SOURCES-1:0]  arb_vec;
    logic                arb_valid;
    logic [ID_WIDTH-1:0] arb_id;

    // Reads have no side effects, so the read strobe carries no information here
    logic unused_rd;
    assign unused_rd = rd;

    assign we = ~cs & ~wr;

    // Bus write decode and pending-bit update; a new pulse beats any clear
    always_comb begin
        w1c    = '0;
        mask_d = mask_q;
        gie_d  = gie_q;
        eoi    = 1'b0;
        if (we) begin
            unique case (addr)
                IRQ_PENDING: w1c = in_data;
                IRQ_MASK:    mask_d = in_data;
                IRQ_CTRL: begin
                    gie_d = in_data[CTL_GIE];
                    eoi   = in_data[CTL_EOI];
                end
                default: ;
            endcase
        end
        eoi_clr   = (state_q == ICAssert && eoi) ? (SOURCES'(1) << active_id_q) : '0;
        pending_d = irq_in | (pending_q & ~w1c & ~eoi_clr);
    end

    // Arbitrate on what survives this cycle's writes; new arrivals wait a round
    assign arb_vec = pending_q & ~w1c & mask_d;

    irq_priority_encoder #(
        .SOURCES  (SOURCES),
        .ID_WIDTH (ID_WIDTH)
    ) u_prio (
        .req   (arb_vec),
        .valid (arb_valid),
        .id    (arb_id)
    );

    // Service FSM next-state and active id capture
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        unique case (state_q)
            ICIdle: begin
                if (gie_q && |(pending_q & mask_q)) begin
                    state_d = ICArbitrate;
                end
            end
            ICArbitrate: begin
                if (gie_d && arb_valid) begin
                    active_id_d = arb_id;
                    state_d     = ICAssert;
                end else begin
                    state_d = ICIdle;
                end
            end
            ICAssert: begin
                // EOI completes; losing pending/mask/GIE aborts without clearing others
                if (eoi || !pending_d[active_id_q] || !mask_d[active_id_q] || !gie_d) begin
                    state_d = ICIdle;
                end
            end
            default: state_d = ICIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ICIdle;
            pending_q   <= '0;
            mask_q      <= '0;
            gie_q       <= 1'b0;
            active_id_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            gie_q       <= gie_d;
            active_id_q <= active_id_d;
        end
    end

    // Register read mux, combinational from addr
    always_comb begin
        out_data = '0;
        case (addr)
            IRQ_PENDING: out_data = pending_q;
            IRQ_MASK:    out_data = mask_q;
            IRQ_ACTIVE:  out_data = DATA_WIDTH'(active_id_q);
            IRQ_CTRL:    out_data[CTL_GIE] = gie_q;
            default:     out_data = '0;
        endcase
    end

    assign cpu_irq    = (state_q == ICAssert);
    assign cpu_irq_id = active_id_q;

endmodule
